// File: rtl/id_stage_pkg.sv
// Shared RV32I decode definitions: widths, opcodes, internal op codes and stage payload types.
// Op codes are grouped so that funct3 can be added to a base value within each format.
package id_stage_pkg;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int OP_W    = 6;

  localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd1,  OP_SLL   = 6'd2,  OP_SLT  = 6'd3,  OP_SLTU  = 6'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd5,  OP_SRL   = 6'd6,  OP_OR   = 6'd7,  OP_AND   = 6'd8;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd9,  OP_SRA   = 6'd10;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd11, OP_SLLI  = 6'd12, OP_SLTI = 6'd13, OP_SLTIU = 6'd14;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd15, OP_SRLI  = 6'd16, OP_ORI  = 6'd17, OP_ANDI  = 6'd18;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd19;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd20, OP_BNE   = 6'd21, OP_BLT  = 6'd24, OP_BGE   = 6'd25;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd26, OP_BGEU  = 6'd27;
  localparam logic [OP_W-1:0] OP_LB    = 6'd28, OP_LH    = 6'd29, OP_LW   = 6'd30;
  localparam logic [OP_W-1:0] OP_LBU   = 6'd32, OP_LHU   = 6'd33;
  localparam logic [OP_W-1:0] OP_SB    = 6'd36, OP_SH    = 6'd37, OP_SW   = 6'd38;
  localparam logic [OP_W-1:0] OP_LUI   = 6'd40, OP_AUIPC = 6'd41, OP_JAL  = 6'd42, OP_JALR  = 6'd43;

  localparam logic [6:0] OPC_LUI    = 7'b0110111, OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111, OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011, OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;
  localparam logic [2:0] F3_ADD  = 3'b000, F3_SLL = 3'b001, F3_SR = 3'b101;

  typedef struct packed {
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic               use_rs1;
    logic               use_rs2;
    logic [XLEN-1:0]    imm;
    logic [OP_W-1:0]    op;
    logic               wreg;
    logic               illegal;
  } dec_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic [XLEN-1:0]    imm;
    logic [OP_W-1:0]    op;
    logic [RADDR_W-1:0] rd;
    logic               wreg;
    logic               illegal;
  } idex_t;

  // Loads still in EX have no data yet; those cases are stalled, never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RADDR_W-1:0] addr,      input logic [XLEN-1:0] rf_data,
    input logic               ex_wen,    input logic            ex_is_load,
    input logic [RADDR_W-1:0] ex_waddr,  input logic [XLEN-1:0] ex_wdata,
    input logic               mem_wen,   input logic [RADDR_W-1:0] mem_waddr,
    input logic [XLEN-1:0]    mem_wdata);
    if (addr == '0) return '0;
    if (ex_wen && !ex_is_load && (ex_waddr == addr)) return ex_wdata;
    if (mem_wen && (mem_waddr == addr)) return mem_wdata;
    return rf_data;
  endfunction
endpackage

// File: rtl/id_stage_if.sv
// ID/EX handshake bundle: id_stage is the master, EX is the slave.
interface id_stage_if;
  import id_stage_pkg::*;
  logic  valid;
  logic  ready;
  idex_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/id_stage_inst_decode.sv
// Combinational RV32I decoder: register fields, read usage, immediate and internal op code.
module id_stage_inst_decode
  import id_stage_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);
  logic [6:0]      opc;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            bad;
  logic            wr;
  dec_t            d;

  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign f7    = inst_i[31:25];
  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    d     = '0;
    bad   = 1'b0;
    wr    = 1'b0;
    d.rs1 = inst_i[19:15];
    d.rs2 = inst_i[24:20];
    case (opc)
      OPC_LUI:   begin d.op = OP_LUI;   d.imm = imm_u; wr = 1'b1; end
      OPC_AUIPC: begin d.op = OP_AUIPC; d.imm = imm_u; wr = 1'b1; end
      OPC_JAL:   begin d.op = OP_JAL;   d.imm = imm_j; wr = 1'b1; end
      OPC_JALR: begin
        d.op = OP_JALR; d.imm = imm_i; d.use_rs1 = 1'b1; wr = 1'b1;
        bad  = (f3 != F3_ADD);
      end
      OPC_BRANCH: begin
        d.op = OP_BEQ + OP_W'(f3); d.imm = imm_b; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
        bad  = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        d.op = OP_LB + OP_W'(f3); d.imm = imm_i; d.use_rs1 = 1'b1; wr = 1'b1;
        bad  = (f3 == 3'd3) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        d.op = OP_SB + OP_W'(f3); d.imm = imm_s; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
        bad  = (f3 > 3'd2);
      end
      OPC_OPIMM: begin
        d.op = OP_ADDI + OP_W'(f3); d.imm = imm_i; d.use_rs1 = 1'b1; wr = 1'b1;
        if (f3 == F3_SLL) bad = (f7 != F7_BASE);
        else if (f3 == F3_SR) begin
          if (f7 == F7_ALT) d.op = OP_SRAI;
          else bad = (f7 != F7_BASE);
        end
      end
      OPC_OP: begin
        d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; wr = 1'b1;
        if (f7 == F7_BASE) d.op = OP_ADD + OP_W'(f3);
        else if ((f7 == F7_ALT) && (f3 == F3_ADD)) d.op = OP_SUB;
        else if ((f7 == F7_ALT) && (f3 == F3_SR)) d.op = OP_SRA;
        else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      d         = '0;
      d.illegal = 1'b1;
    end else begin
      d.rd   = wr ? inst_i[11:7] : '0;
      d.wreg = wr && (inst_i[11:7] != '0);
    end
  end

  assign dec_o = d;
endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register-file reads, EX/MEM forwarding, load-use stall and the
// ID/EX output register behind a valid/ready handshake.
module id_stage
  import id_stage_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid_i,
  input  logic [XLEN-1:0]    in_pc_i,
  input  logic [31:0]        in_inst_i,
  output logic               in_ready_o,
  output logic               read1_o,
  output logic               read2_o,
  output logic [RADDR_W-1:0] reg1_addr_o,
  output logic [RADDR_W-1:0] reg2_addr_o,
  input  logic [XLEN-1:0]    reg1_data_i,
  input  logic [XLEN-1:0]    reg2_data_i,
  input  logic               ex_wen_i,
  input  logic [RADDR_W-1:0] ex_waddr_i,
  input  logic [XLEN-1:0]    ex_wdata_i,
  input  logic               ex_is_load_i,
  input  logic               mem_wen_i,
  input  logic [RADDR_W-1:0] mem_waddr_i,
  input  logic [XLEN-1:0]    mem_wdata_i,
  input  logic               flush_i,
  id_stage_if.master         idex
);
  dec_t  dec;
  logic  hazard;
  logic  valid_q, valid_d;
  idex_t data_q, data_d;

  id_stage_inst_decode u_decode (
    .inst_i (in_inst_i),
    .dec_o  (dec)
  );

  assign read1_o     = reset & dec.use_rs1;
  assign read2_o     = reset & dec.use_rs2;
  assign reg1_addr_o = read1_o ? dec.rs1 : '0;
  assign reg2_addr_o = read2_o ? dec.rs2 : '0;

  assign hazard = ex_wen_i & ex_is_load_i & (ex_waddr_i != '0) &
                  ((read1_o & (dec.rs1 == ex_waddr_i)) | (read2_o & (dec.rs2 == ex_waddr_i)));

  // Flush always consumes the wrong-path word so IF can move on to the redirect target.
  assign in_ready_o = reset & (flush_i | (!hazard & (!valid_q | idex.ready)));

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!reset || flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_d        = 1'b1;
      data_d.pc      = in_pc_i;
      data_d.op1     = fwd_sel(reg1_addr_o, reg1_data_i, ex_wen_i, ex_is_load_i, ex_waddr_i,
                               ex_wdata_i, mem_wen_i, mem_waddr_i, mem_wdata_i);
      data_d.op2     = fwd_sel(reg2_addr_o, reg2_data_i, ex_wen_i, ex_is_load_i, ex_waddr_i,
                               ex_wdata_i, mem_wen_i, mem_waddr_i, mem_wdata_i);
      data_d.imm     = dec.imm;
      data_d.op      = dec.op;
      data_d.rd      = dec.rd;
      data_d.wreg    = dec.wreg;
      data_d.illegal = dec.illegal;
    end else if (idex.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    valid_q <= valid_d;
    data_q  <= data_d;
  end

  assign idex.valid = valid_q;
  assign idex.data  = data_q;
endmodule

// File: tb/tb_id_stage.sv
// Scenario bench for id_stage: expected ID/EX payloads are queued at issue and checked at output.
module tb_id_stage;
  import id_stage_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic [XLEN-1:0]    in_pc = '0;
  logic [31:0]        in_inst = 32'h0000_0013;
  logic               in_ready, read1, read2;
  logic [RADDR_W-1:0] reg1_addr, reg2_addr;
  logic [XLEN-1:0]    reg1_data, reg2_data;
  logic               ex_wen = 1'b0, ex_is_load = 1'b0, mem_wen = 1'b0, flush = 1'b0;
  logic [RADDR_W-1:0] ex_waddr = '0, mem_waddr = '0;
  logic [XLEN-1:0]    ex_wdata = '0, mem_wdata = '0;
  logic [XLEN-1:0]    rf [32];

  int    checks = 0;
  int    failures = 0;
  idex_t exp_q [$];
  idex_t e;

  id_stage_if idex_bus ();

  id_stage dut (
    .clock(clock), .reset(reset),
    .in_valid_i(in_valid), .in_pc_i(in_pc), .in_inst_i(in_inst), .in_ready_o(in_ready),
    .read1_o(read1), .read2_o(read2), .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
    .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
    .ex_wen_i(ex_wen), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .mem_wen_i(mem_wen), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .flush_i(flush), .idex(idex_bus)
  );

  always #5 clock = ~clock;
  assign reg1_data = rf[reg1_addr];
  assign reg2_data = rf[reg2_addr];

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction
  function automatic idex_t mk(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] imm, input logic [OP_W-1:0] op, input logic [4:0] rd,
                               input logic wreg, input logic ill);
    idex_t r;
    r.pc = pc; r.op1 = op1; r.op2 = op2; r.imm = imm;
    r.op = op; r.rd = rd; r.wreg = wreg; r.illegal = ill;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_pc = 32'h40; in_inst = enc_r(F7_BASE, 5'd2, 5'd1, 3'd0, 5'd3);
    tick(); tick();
    checks++; if (idex_bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", idex_bus.valid); end
    checks++; if (idex_bus.data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", idex_bus.data); end
    checks++; if ({in_ready, read1, read2} !== 3'b000) begin failures++; $display("FAIL reset_comb got=%b want=000", {in_ready, read1, read2}); end
    reset = 1'b1; in_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_pc = 32'h100; in_inst = enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPC_OPIMM); #1;
    checks++; if ({in_ready, read1, read2, reg1_addr} !== {3'b110, 5'd0}) begin failures++; $display("FAIL addi_comb got=%b want=11000000", {in_ready, read1, read2, reg1_addr}); end
    exp_q.push_back(mk(32'h100, 0, 0, 32'd5, OP_ADDI, 5'd1, 1'b1, 1'b0));
    tick(); in_valid = 1'b0;
    checks++; if (idex_bus.valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b want=1", idex_bus.valid); end
    e = exp_q.pop_front();
    checks++; if (idex_bus.data !== e) begin failures++; $display("FAIL addi_data got=%h want=%h", idex_bus.data, e); end
    tick();
    checks++; if (idex_bus.valid !== 1'b0) begin failures++; $display("FAIL addi_drain got=%b want=0", idex_bus.valid); end
  endtask

  task automatic test_forward();
    logic [31:0] ins [4];
    logic [XLEN-1:0] x1 [4], x2 [4];
    logic [OP_W-1:0] ops [4];
    logic [37:0] exs [4], mems [4];
    ins  = '{enc_r(F7_BASE, 5'd2, 5'd1, 3'd0, 5'd3), enc_r(F7_BASE, 5'd1, 5'd1, 3'd0, 5'd4),
             enc_r(F7_ALT, 5'd2, 5'd1, 3'd0, 5'd5), enc_r(F7_BASE, 5'd2, 5'd0, 3'd0, 5'd6)};
    exs  = '{{1'b1, 5'd1, 32'h7}, {1'b1, 5'd1, 32'hAA}, {1'b0, 5'd1, 32'hCC}, {1'b1, 5'd0, 32'h55}};
    mems = '{{1'b1, 5'd2, 32'h9}, {1'b1, 5'd1, 32'hBB}, {1'b0, 5'd2, 32'hDD}, {1'b1, 5'd2, 32'h66}};
    x1   = '{32'h7, 32'hAA, 32'h11, 32'h0};
    x2   = '{32'h9, 32'hAA, 32'h22, 32'h66};
    ops  = '{OP_ADD, OP_ADD, OP_SUB, OP_ADD};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * i); in_inst = ins[i];
      {ex_wen, ex_waddr, ex_wdata} = exs[i]; {mem_wen, mem_waddr, mem_wdata} = mems[i]; #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fwd_ready[%0d] got=%b want=1", i, in_ready); end
      exp_q.push_back(mk(in_pc, x1[i], x2[i], 32'd0, ops[i], 5'(3 + i), 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front();
      checks++; if ({idex_bus.valid, idex_bus.data} !== {1'b1, e}) begin failures++; $display("FAIL fwd_data[%0d] got=%b/%h want=1/%h", i, idex_bus.valid, idex_bus.data, e); end
    end
    in_valid = 1'b0; ex_wen = 1'b0; mem_wen = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; in_pc = 32'h300; in_inst = enc_i(12'd3, 5'd0, 3'd0, 5'd7, OPC_OPIMM); #1;
    exp_q.push_back(mk(32'h300, 0, 0, 32'd3, OP_ADDI, 5'd7, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front();
    checks++; if ({idex_bus.valid, idex_bus.data} !== {1'b1, e}) begin failures++; $display("FAIL lu_first got=%b/%h want=1/%h", idex_bus.valid, idex_bus.data, e); end
    in_pc = 32'h304; in_inst = enc_i(12'd1, 5'd5, 3'd0, 5'd6, OPC_OPIMM);
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hDEAD; #1;
    checks++; if ({in_ready, read1, reg1_addr} !== {2'b01, 5'd5}) begin failures++; $display("FAIL lu_stall got=%b want=0100101", {in_ready, read1, reg1_addr}); end
    tick();
    checks++; if (idex_bus.valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b want=0", idex_bus.valid); end
    ex_wen = 1'b0; ex_is_load = 1'b0; mem_wen = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'h1234; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_release got=%b want=1", in_ready); end
    exp_q.push_back(mk(32'h304, 32'h1234, 0, 32'd1, OP_ADDI, 5'd6, 1'b1, 1'b0));
    tick(); mem_wen = 1'b0;
    e = exp_q.pop_front();
    checks++; if ({idex_bus.valid, idex_bus.data} !== {1'b1, e}) begin failures++; $display("FAIL lu_issue got=%b/%h want=1/%h", idex_bus.valid, idex_bus.data, e); end
    // rs2-side hazard, then issue from the register file once the load has moved on
    in_pc = 32'h308; in_inst = enc_r(F7_BASE, 5'd5, 5'd1, 3'd0, 5'd8);
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd5; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_rs2_stall got=%b want=0", in_ready); end
    tick();
    ex_wen = 1'b0; ex_is_load = 1'b0; #1;
    exp_q.push_back(mk(32'h308, 32'h11, 32'h55, 32'd0, OP_ADD, 5'd8, 1'b1, 1'b0));
    tick(); in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++; if ({idex_bus.valid, idex_bus.data} !== {1'b1, e}) begin failures++; $display("FAIL lu_rs2_issue got=%b/%h want=1/%h", idex_bus.valid, idex_bus.data, e); end
    tick();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_pc = 32'h400; in_inst = enc_i(12'h7FF, 5'd0, 3'd0, 5'd8, OPC_OPIMM); #1;
    exp_q.push_back(mk(32'h400, 0, 0, 32'h7FF, OP_ADDI, 5'd8, 1'b1, 1'b0));
    tick();
    idex_bus.ready = 1'b0; in_pc = 32'h404; in_inst = enc_i(12'hFFF, 5'd0, 3'd0, 5'd9, OPC_OPIMM);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b want=0", k, in_ready); end
      tick();
      checks++; if ({idex_bus.valid, idex_bus.data} !== {1'b1, exp_q[0]}) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h want=1/%h", k, idex_bus.valid, idex_bus.data, exp_q[0]); end
    end
    idex_bus.ready = 1'b1;
    e = exp_q.pop_front();
    checks++; if (idex_bus.data !== e) begin failures++; $display("FAIL bp_first got=%h want=%h", idex_bus.data, e); end
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b want=1", in_ready); end
    exp_q.push_back(mk(32'h404, 0, 0, 32'hFFFF_FFFF, OP_ADDI, 5'd9, 1'b1, 1'b0));
    tick(); in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++; if ({idex_bus.valid, idex_bus.data} !== {1'b1, e}) begin failures++; $display("FAIL bp_second got=%b/%h want=1/%h", idex_bus.valid, idex_bus.data, e); end
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_pc = 32'h500; in_inst = enc_i(12'd10, 5'd0, 3'd0, 5'd10, OPC_OPIMM); #1;
    exp_q.push_back(mk(32'h500, 0, 0, 32'd10, OP_ADDI, 5'd10, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front();
    checks++; if ({idex_bus.valid, idex_bus.data} !== {1'b1, e}) begin failures++; $display("FAIL fl_pre got=%b/%h want=1/%h", idex_bus.valid, idex_bus.data, e); end
    idex_bus.ready = 1'b0; flush = 1'b1; in_pc = 32'h504; in_inst = enc_r(F7_BASE, 5'd0, 5'd5, 3'd0, 5'd11);
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd5; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fl_ready got=%b want=1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; ex_wen = 1'b0; ex_is_load = 1'b0; idex_bus.ready = 1'b1;
    checks++; if (idex_bus.valid !== 1'b0) begin failures++; $display("FAIL fl_kill got=%b want=0", idex_bus.valid); end
    tick();
    checks++; if (idex_bus.valid !== 1'b0) begin failures++; $display("FAIL fl_dropped got=%b want=0", idex_bus.valid); end
  endtask

  task automatic test_formats();
    logic [31:0] ins [12];
    idex_t       xp [12];
    logic [1:0]  rds [12];
    logic        ld5 [12];
    ins = '{enc_i(12'd1, 5'd0, 3'd0, 5'd0, OPC_OPIMM), 32'h0002_807F,
            {20'h12345, 5'd5, OPC_LUI}, enc_s(12'hFFC, 5'd2, 5'd1, 3'b010),
            enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000), enc_j(21'h800, 5'd1),
            enc_i(12'hFFF, 5'd2, 3'd0, 5'd1, OPC_JALR), enc_i(12'h403, 5'd1, 3'b101, 5'd4, OPC_OPIMM),
            enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), enc_i(12'd8, 5'd1, 3'b010, 5'd3, OPC_LOAD),
            enc_b(13'h1000, 5'd2, 5'd1, 3'b001), {20'hFFFFF, 5'd7, OPC_AUIPC}};
    xp  = '{mk(0, 0, 0, 32'd1, OP_ADDI, 5'd0, 1'b0, 1'b0), mk(0, 0, 0, 0, OP_NOP, 5'd0, 1'b0, 1'b1),
            mk(0, 0, 0, 32'h1234_5000, OP_LUI, 5'd5, 1'b1, 1'b0),
            mk(0, 32'h11, 32'h22, 32'hFFFF_FFFC, OP_SW, 5'd0, 1'b0, 1'b0),
            mk(0, 32'h11, 32'h22, 32'hFFFF_FFF8, OP_BEQ, 5'd0, 1'b0, 1'b0),
            mk(0, 0, 0, 32'h800, OP_JAL, 5'd1, 1'b1, 1'b0),
            mk(0, 32'h22, 0, 32'hFFFF_FFFF, OP_JALR, 5'd1, 1'b1, 1'b0),
            mk(0, 32'h11, 0, 32'h403, OP_SRAI, 5'd4, 1'b1, 1'b0),
            mk(0, 0, 0, 0, OP_NOP, 5'd0, 1'b0, 1'b1),
            mk(0, 32'h11, 0, 32'd8, OP_LW, 5'd3, 1'b1, 1'b0),
            mk(0, 32'h11, 32'h22, 32'hFFFF_F000, OP_BNE, 5'd0, 1'b0, 1'b0),
            mk(0, 0, 0, 32'hFFFF_F000, OP_AUIPC, 5'd7, 1'b1, 1'b0)};
    rds = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 2'b00};
    ld5 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_pc = 32'h600 + 32'(4 * i); in_inst = ins[i];
      ex_wen = ld5[i]; ex_is_load = ld5[i]; ex_waddr = 5'd5; #1;
      checks++; if ({in_ready, read1, read2} !== {1'b1, rds[i]}) begin failures++; $display("FAIL fmt_comb[%0d] got=%b want=1%b", i, {in_ready, read1, read2}, rds[i]); end
      e = xp[i]; e.pc = in_pc;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      checks++; if ({idex_bus.valid, idex_bus.data} !== {1'b1, e}) begin failures++; $display("FAIL fmt_data[%0d] got=%b/%h want=1/%h", i, idex_bus.valid, idex_bus.data, e); end
    end
    in_valid = 1'b0; ex_wen = 1'b0; ex_is_load = 1'b0;
    tick();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    rf[1] = 32'h11; rf[2] = 32'h22; rf[5] = 32'h55;
    idex_bus.ready = 1'b1;
    test_reset();
    test_addi();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_formats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the scenario sequence completed");
    $fatal(1);
  end
endmodule
